// File: rtl/multdiv_sequencer.sv
// Control FSM for the shared iterative multiply/divide datapath: accepts a start,
// strobes the datapath for a fixed iteration count, then holds the result handshake.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 16,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic [4:0]       dest_in,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_is_div,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [4:0]       dest_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] nxt_count;
    logic             nxt_is_div, nxt_exc;
    logic [4:0]       nxt_dest;
    logic             req, accept, start_div, start_exc, last_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            step_count     <= '0;
            dp_is_div      <= 1'b0;
            data_exception <= 1'b0;
            dest_out       <= '0;
        end else begin
            state          <= nxt_state;
            step_count     <= nxt_count;
            dp_is_div      <= nxt_is_div;
            data_exception <= nxt_exc;
            dest_out       <= nxt_dest;
        end
    end

    always_comb begin
        req       = ctrl_MULT | ctrl_DIV;
        // Multiply wins when both starts arrive together.
        start_div = ctrl_DIV & ~ctrl_MULT;
        start_exc = start_div & divisor_zero;
        accept    = ((state == IDLE) || (state == DONE && wb_ready)) && req && !flush;
        last_step = (step_count == (dp_is_div ? DIV_LAST : MULT_LAST));

        nxt_state  = state;
        nxt_count  = step_count;
        nxt_is_div = dp_is_div;
        nxt_exc    = data_exception;
        nxt_dest   = dest_out;

        dp_load        = accept;
        dp_step        = (state == RUN);
        data_resultRDY = (state == DONE);
        busy           = (state == RUN) || (state == DONE && !wb_ready) || accept;

        case (state)
            IDLE: nxt_state = IDLE;
            RUN: begin
                if (last_step) nxt_state = DONE;
                else           nxt_count = step_count + CNT_W'(1);
            end
            DONE: if (wb_ready) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        // A zero-divisor divide skips the datapath and reports straight away.
        if (accept) begin
            nxt_state  = start_exc ? DONE : RUN;
            nxt_count  = '0;
            nxt_is_div = start_div;
            nxt_exc    = start_exc;
            nxt_dest   = dest_in;
        end

        if (flush) begin
            nxt_state = IDLE;
            nxt_count = '0;
            nxt_exc   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: stimulus pushes expected results into a
// queue, a negedge monitor pops and checks them at each writeback handshake.
module tb_multdiv_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ctrl_MULT, ctrl_DIV, divisor_zero, flush, wb_ready;
    logic [4:0] dest_in;
    logic       dp_load, dp_step, dp_is_div, busy, data_resultRDY, data_exception;
    logic [5:0] step_count;
    logic [4:0] dest_out;

    typedef struct {
        int dest;
        int exc;
        int steps;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    multdiv_sequencer #(.MULT_CYCLES(16), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .divisor_zero(divisor_zero), .dest_in(dest_in), .flush(flush), .wb_ready(wb_ready),
        .dp_load(dp_load), .dp_step(dp_step), .dp_is_div(dp_is_div), .step_count(step_count),
        .busy(busy), .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .dest_out(dest_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: counts steps per operation and checks each result at handshake.
    int  steps    = 0;
    int  load_cyc = 0;
    int  rdy_cyc  = 0;
    bit  rdy_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (data_resultRDY && !rdy_seen) begin
                rdy_cyc  = cyc;
                rdy_seen = 1;
            end
            if (dp_step) steps++;
            if (data_resultRDY && wb_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_dest", int'(dest_out), e.dest);
                    chk("mon_exc", int'(data_exception), e.exc);
                    chk("mon_steps", steps, e.steps);
                    chk("mon_latency", rdy_cyc - load_cyc, e.lat);
                end
                rdy_seen = 0;
            end
            if (dp_load) begin
                load_cyc = cyc;
                steps    = 0;
                rdy_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        ctrl_MULT = 0; ctrl_DIV = 0; divisor_zero = 0; flush = 0;
    endtask

    task automatic push(int dest, int exc, int st, int lat);
        exp_t e;
        e.dest = dest; e.exc = exc; e.steps = st; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_rdy(int budget);
        int n = 0;
        while (!data_resultRDY && n < budget) begin
            tick();
            n++;
        end
        if (!data_resultRDY) chk("wait_rdy_timeout", 0, 1);
    endtask

    initial begin
        int hits;
        reset_n = 0; wb_ready = 0; dest_in = 0;
        clear_req();
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({dp_load, dp_step, data_resultRDY}), 0);
        chk("rst_regs", int'({dp_is_div, data_exception, dest_out, step_count}), 0);
        tick(); tick();
        reset_n = 1;
        tick();

        // Multiply, writeback always ready.
        wb_ready = 1; ctrl_MULT = 1; dest_in = 7;
        push(7, 0, 16, 17);
        #1;
        chk("mul_load", int'(dp_load), 1);
        chk("mul_busy_c0", int'(busy), 1);
        tick(); clear_req();
        chk("mul_step_c1", int'(dp_step), 1);
        repeat (16) tick();
        chk("mul_rdy_c17", int'(data_resultRDY), 1);
        chk("mul_busy_c17", int'(busy), 0);
        chk("mul_cnt_c17", int'(step_count), 15);
        tick();
        chk("mul_rdy_c18", int'(data_resultRDY), 0);

        // Divide with writeback stalled until cycle 40.
        wb_ready = 0; ctrl_DIV = 1; dest_in = 12;
        push(12, 0, 32, 33);
        tick(); clear_req();
        repeat (32) tick();
        chk("div_rdy_c33", int'(data_resultRDY), 1);
        chk("div_busy_c33", int'(busy), 1);
        repeat (7) tick();
        chk("div_rdy_c40", int'(data_resultRDY), 1);
        wb_ready = 1;
        #1;
        chk("div_busy_wb", int'(busy), 0);
        tick();
        chk("div_idle_c41", int'({data_resultRDY, busy}), 0);

        // Divide by zero.
        ctrl_DIV = 1; divisor_zero = 1; dest_in = 3;
        push(3, 1, 0, 1);
        #1;
        chk("dbz_load", int'(dp_load), 1);
        tick(); clear_req();
        chk("dbz_rdy", int'(data_resultRDY), 1);
        chk("dbz_exc", int'(data_exception), 1);
        chk("dbz_dest", int'(dest_out), 3);
        chk("dbz_nostep", int'(dp_step), 0);
        tick();

        // Back-to-back: divide accepted in the multiply's DONE cycle.
        ctrl_MULT = 1; dest_in = 9;
        push(9, 0, 16, 17);
        tick(); clear_req();
        repeat (16) tick();
        ctrl_DIV = 1; dest_in = 21;
        push(21, 0, 32, 33);
        #1;
        chk("b2b_rdy", int'(data_resultRDY), 1);
        chk("b2b_load", int'(dp_load), 1);
        tick(); clear_req();
        chk("b2b_is_div", int'(dp_is_div), 1);
        chk("b2b_run", int'(dp_step), 1);
        chk("b2b_cnt", int'(step_count), 0);
        wait_rdy(40);
        tick();

        // Flush in cycle 5 of a multiply.
        ctrl_MULT = 1; dest_in = 4;
        tick(); clear_req();
        repeat (4) tick();
        flush = 1;
        tick(); flush = 0;
        chk("flush_busy", int'(busy), 0);
        chk("flush_cnt", int'(step_count), 0);
        chk("flush_step", int'(dp_step), 0);
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            if (data_resultRDY) hits++;
            tick();
        end
        chk("flush_no_rdy", hits, 0);

        // Request coincident with flush is refused.
        ctrl_MULT = 1; flush = 1;
        #1;
        chk("flush_req_noload", int'(dp_load), 0);
        tick(); clear_req();
        chk("flush_req_idle", int'(busy), 0);

        // Asynchronous reset in the middle of RUN.
        ctrl_MULT = 1; dest_in = 30;
        tick(); clear_req();
        repeat (3) tick();
        #2 reset_n = 0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_step", int'(dp_step), 0);
        chk("arst_regs", int'({dest_out, step_count, dp_is_div}), 0);
        tick();
        reset_n = 1;
        tick();

        // MULT and DIV together: multiply wins; a stray MULT during RUN is ignored.
        ctrl_MULT = 1; ctrl_DIV = 1; divisor_zero = 1; dest_in = 17;
        push(17, 0, 16, 17);
        tick(); clear_req();
        chk("conf_is_div", int'(dp_is_div), 0);
        chk("conf_cnt0", int'(step_count), 0);
        repeat (3) tick();
        ctrl_MULT = 1;
        #1;
        chk("conf_noload", int'(dp_load), 0);
        tick(); clear_req();
        chk("conf_cnt4", int'(step_count), 4);
        wait_rdy(20);
        tick(); tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
